trigger_wheel_gen: RTL and testbench
====================================

# trigger_wheel_gen

Parametrised, synthesizable crank/cam trigger-wheel signal generator for the hwag test environment and for on-board self-test. It produces a TEETH-minus-MISSING crank tooth signal (default 60-2), a two-revolution cam signal and a tooth index. Tooth period can ramp toward a target so acceleration and deceleration profiles need no stimulus process. It replaces hand-written wheel stimulus and can drive `hwag.cap_in` directly.

## Interface
- TEETH, 60, physical tooth positions per revolution (≥ 4)
- MISSING, 2, gap teeth at positions TEETH-MISSING..TEETH-1 (1..TEETH-2)
- PERIOD_W, 16, width of period/step fields, in clk cycles
- CAM_ON, 4, first tooth index with cam high (odd revolution)
- CAM_OFF, 54, first tooth index with cam low again (CAM_ON < CAM_OFF ≤ TEETH)
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin generation from tooth 0, revolution 0
- stop  in  1  pulse: request halt at end of current revolution
- period_init  in  PERIOD_W  slot length (cycles) of first slot
- period_target  in  PERIOD_W  slot length the ramp converges to
- period_step  in  PERIOD_W  unsigned ramp increment per slot (0 = constant)
- vr  out  1  crank tooth signal
- cam  out  1  cam signal
- tooth_idx  out  $clog2(TEETH)  current slot index
- rev  out  1  revolution parity (0/1 of 720° cycle)
- sync  out  1  one-cycle pulse on first cycle of slot 0
- busy  out  1  high in RUN/STOPPING

## Operation
- States: IDLE, RUN, STOPPING.
- IDLE: start → RUN; tooth_idx=0, rev=0, phase=0, cur_period=clamp(period_init); stop ignored.
- RUN: stop → STOPPING (latched); start ignored.
- STOPPING: continues normally; at end of slot TEETH-1 → IDLE instead of wrapping. start ignored.
- clamp(x) = max(x, 4). Applies to period_init and period_target.
- Slot: phase counts 0..cur_period-1. At phase=cur_period-1 the slot ends:
  - phase → 0, tooth_idx → tooth_idx+1.
  - At TEETH-1, tooth_idx → 0 and rev toggles.
  - Ramp update, t = clamp(period_target): cur<t → min(cur+step, t); cur>t → max(cur-step, t); equal → unchanged. Computed in PERIOD_W+1 bits; no overshoot and no wrap (result ≤ 2^PERIOD_W-1).
- vr = 1 iff state≠IDLE, tooth_idx < TEETH-MISSING, and phase ≥ cur_period>>1. Low half first, high half second; gap slots stay low.
- cam = 1 iff state≠IDLE, rev=1, and CAM_ON ≤ tooth_idx < CAM_OFF.
- sync = 1 iff state≠IDLE, tooth_idx=0, phase=0.
- period_* inputs are sampled only at start (init) and at slot ends (target, step); changes mid-slot take effect at the next slot end.

## Timing
- Reset values: vr=0, cam=0, tooth_idx=0, rev=0, sync=0, busy=0, state=IDLE, phase=0, cur_period=0.
- rst has priority over start/stop. rst mid-operation returns all outputs to reset values at the next edge.
- start sampled at edge N → busy=1, sync=1, tooth_idx=0 from edge N+1. First vr rise at edge N+1+(cur_period>>1).
- All outputs registered or derived from registered state only. No combinational path from inputs to outputs.
- Slot k length is exactly cur_period_k cycles. One revolution = sum of TEETH slot lengths.
- stop at any cycle of revolution R → busy falls on the edge after slot TEETH-1 of R completes. A stop in slot TEETH-1's last cycle still finishes that slot.
- Simultaneous start+stop in IDLE → start wins and stop is dropped.

## Test plan
- Constant wheel: period_init=period_target=8, step=0, start.
  - vr: 58 pulses of 4 low/4 high, then 16 cycles low.
  - sync every 480 cycles; rev toggles every 480 cycles.
- Cam: same run over 2 revolutions.
  - cam high only in rev=1, for tooth_idx 4..53 = 50×8 = 400 cycles.
  - cam low throughout rev=0.
- Ramp: init=16, target=64, step=3.
  - Slot lengths 16,19,…,61,64, then 64 constant, with no overshoot.
  - Repeat with init=64, target=16: descending to 16.
- Clamp/saturation: init=1 gives first slot 4 cycles.
  - PERIOD_W=8, init=250, target=255, step=10: second slot = 255.
- Stop: stop asserted at tooth 10 of rev 0 → generation continues through slot 59; busy=0 the following edge; no second sync. start during STOPPING is ignored.
- Reset mid-run: rst at tooth 30, rev 1 → next edge all outputs 0, state IDLE. A later start restarts at tooth 0, rev 0.

Source files
------------

// File: rtl/trigger_wheel_gen.sv
// ---------------------------------------------------------------------------
// trigger_wheel_gen
//
// Crank/cam trigger-wheel generator. Produces a TEETH-minus-MISSING crank
// tooth signal, a cam signal that is high for part of every second
// revolution, and the current tooth index. The slot length can ramp toward
// a target period by a fixed step per slot, so acceleration and
// deceleration profiles come out of the generator itself.
//
// Ports:
//   clk            system clock, single domain
//   rst            synchronous, active-high reset
//   start          pulse: begin at tooth 0, revolution 0 (honoured in IDLE)
//   stop           pulse: halt at the end of the current revolution
//   period_init    length in clk cycles of the first slot (clamped to >= 4)
//   period_target  length the ramp converges to (clamped to >= 4)
//   period_step    unsigned ramp increment per slot, 0 keeps period constant
//   vr             crank tooth signal, low half then high half of a slot
//   cam            cam signal, high in odd revolution for CAM_ON..CAM_OFF-1
//   tooth_idx      current slot index 0..TEETH-1
//   rev            revolution parity within the 720 degree cycle
//   sync           one-cycle pulse on the first cycle of slot 0
//   busy           high while generating (RUN or STOPPING)
// ---------------------------------------------------------------------------
module trigger_wheel_gen #(
    parameter int TEETH    = 60,
    parameter int MISSING  = 2,
    parameter int PERIOD_W = 16,
    parameter int CAM_ON   = 4,
    parameter int CAM_OFF  = 54
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [PERIOD_W-1:0]      period_init,
    input  logic [PERIOD_W-1:0]      period_target,
    input  logic [PERIOD_W-1:0]      period_step,
    output logic                     vr,
    output logic                     cam,
    output logic [$clog2(TEETH)-1:0] tooth_idx,
    output logic                     rev,
    output logic                     sync,
    output logic                     busy
);

    localparam int IDX_W = $clog2(TEETH);

    // Tooth bounds are compared one bit wider than tooth_idx so that a bound
    // equal to TEETH still fits when TEETH is a power of two.
    localparam logic [IDX_W-1:0]    LAST_TOOTH = IDX_W'(TEETH - 1);
    localparam logic [IDX_W:0]      FIRST_GAP  = (IDX_W + 1)'(TEETH - MISSING);
    localparam logic [IDX_W:0]      CAM_FIRST  = (IDX_W + 1)'(CAM_ON);
    localparam logic [IDX_W:0]      CAM_LAST   = (IDX_W + 1)'(CAM_OFF);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(4);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PERIOD_W-1:0]  phase;
    logic [PERIOD_W-1:0]  cur_period;
    logic [PERIOD_W-1:0]  period_next;
    logic [PERIOD_W-1:0]  init_clamped;
    logic [PERIOD_W-1:0]  target_clamped;
    logic [PERIOD_W:0]    ramp_up_sum;
    logic [PERIOD_W:0]    ramp_down_room;
    logic                 slot_end;
    logic                 last_slot_end;
    logic                 active;
    logic [IDX_W:0]       tooth_wide;

    // Slots shorter than four cycles would leave no room for distinct low
    // and high halves, so both the initial and target periods are floored.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] x);
        return (x < MIN_PERIOD) ? MIN_PERIOD : x;
    endfunction

    assign init_clamped   = clamp_period(period_init);
    assign target_clamped = clamp_period(period_target);
    assign active         = (state != IDLE);
    assign tooth_wide     = {1'b0, tooth_idx};

    // A slot ends on its last phase count; the final slot of a revolution is
    // the point where wrapping or halting is decided.
    always_comb begin
        slot_end      = 1'b0;
        last_slot_end = 1'b0;
        if (active && (phase == (cur_period - PERIOD_W'(1)))) begin
            slot_end      = 1'b1;
            last_slot_end = (tooth_idx == LAST_TOOTH);
        end
    end

    // Ramp toward the target by one step per slot. The arithmetic is one bit
    // wider than the period so that a large step neither wraps nor jumps past
    // the target; the result is always bounded by the target itself.
    always_comb begin
        period_next    = cur_period;
        ramp_up_sum    = {1'b0, cur_period} + {1'b0, period_step};
        ramp_down_room = {1'b0, cur_period} - {1'b0, target_clamped};
        if (cur_period < target_clamped) begin
            if (ramp_up_sum > {1'b0, target_clamped}) begin
                period_next = target_clamped;
            end else begin
                period_next = ramp_up_sum[PERIOD_W-1:0];
            end
        end else if (cur_period > target_clamped) begin
            if ({1'b0, period_step} > ramp_down_room) begin
                period_next = target_clamped;
            end else begin
                period_next = cur_period - period_step;
            end
        end
    end

    // Next-state logic. A stop that arrives on the very last cycle of a
    // revolution goes straight to IDLE, because that same edge already
    // completes slot TEETH-1 and there is no further slot to finish.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = last_slot_end ? IDLE : STOPPING;
                end
            end
            STOPPING: begin
                if (last_slot_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wheel position: phase within the slot, tooth index, revolution parity
    // and the current slot length. Period inputs are only looked at on start
    // and at slot ends, so mid-slot changes wait for the next boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= '0;
            cur_period <= '0;
            tooth_idx  <= '0;
            rev        <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                phase      <= '0;
                cur_period <= init_clamped;
                tooth_idx  <= '0;
                rev        <= 1'b0;
            end
        end else if (slot_end) begin
            phase      <= '0;
            cur_period <= period_next;
            if (tooth_idx == LAST_TOOTH) begin
                tooth_idx <= '0;
                rev       <= ~rev;
            end else begin
                tooth_idx <= tooth_idx + IDX_W'(1);
            end
        end else begin
            phase <= phase + PERIOD_W'(1);
        end
    end

    // Outputs are decoded purely from registered state. The tooth signal is
    // low for the first half of a slot and high for the second, and gap
    // slots stay low for their whole length.
    always_comb begin
        vr   = 1'b0;
        cam  = 1'b0;
        sync = 1'b0;
        busy = active;
        if (active) begin
            vr   = (tooth_wide < FIRST_GAP) && (phase >= (cur_period >> 1));
            cam  = rev && (tooth_wide >= CAM_FIRST) && (tooth_wide < CAM_LAST);
            sync = (tooth_idx == '0) && (phase == '0);
        end
    end

endmodule

// File: tb/tb_trigger_wheel_gen.sv
// ---------------------------------------------------------------------------
// tb_trigger_wheel_gen
//
// Directed self-checking bench for trigger_wheel_gen. The main instance uses
// the default 60-2 wheel; a second, narrow instance (PERIOD_W=8, 8 teeth)
// exercises saturation of the ramp at the top of the period range.
// Outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_trigger_wheel_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] period_init = '0;
    logic [15:0] period_target = '0;
    logic [15:0] period_step = '0;
    logic        vr;
    logic        cam;
    logic [5:0]  tooth_idx;
    logic        rev;
    logic        sync;
    logic        busy;

    logic        start8 = 1'b0;
    logic        stop8 = 1'b0;
    logic [7:0]  period_init8 = '0;
    logic [7:0]  period_target8 = '0;
    logic [7:0]  period_step8 = '0;
    logic        vr8;
    logic        cam8;
    logic [2:0]  tooth_idx8;
    logic        rev8;
    logic        sync8;
    logic        busy8;

    int checks = 0;
    int errors = 0;
    int slot_len [32];

    trigger_wheel_gen dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .period_init(period_init), .period_target(period_target),
        .period_step(period_step), .vr(vr), .cam(cam),
        .tooth_idx(tooth_idx), .rev(rev), .sync(sync), .busy(busy)
    );

    trigger_wheel_gen #(
        .TEETH(8), .MISSING(2), .PERIOD_W(8), .CAM_ON(1), .CAM_OFF(4)
    ) dut8 (
        .clk(clk), .rst(rst), .start(start8), .stop(stop8),
        .period_init(period_init8), .period_target(period_target8),
        .period_step(period_step8), .vr(vr8), .cam(cam8),
        .tooth_idx(tooth_idx8), .rev(rev8), .sync(sync8), .busy(busy8)
    );

    always #5 clk = ~clk;

    // Global watchdog so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Pulse start for one edge; on return the sample point is cycle 0 of slot 0.
    task automatic start_run(input int init, input int target, input int step);
        period_init   = 16'(init);
        period_target = 16'(target);
        period_step   = 16'(step);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Record the length in cycles of the next n slots of the main instance.
    task automatic measure_slots(input int n);
        int prev_idx;
        int len;
        int k;
        int guard;
        prev_idx = int'(tooth_idx);
        len = 1;
        k = 0;
        guard = 0;
        while (k < n && guard < 20000) begin
            tick();
            guard++;
            if (int'(tooth_idx) != prev_idx) begin
                slot_len[k] = len;
                k++;
                len = 1;
                prev_idx = int'(tooth_idx);
            end else begin
                len++;
            end
        end
        checks++;
        if (k < n) begin
            errors++;
            $display("[TB] FAIL slot_measure: got %0d slots expected %0d", k, n);
        end
    endtask

    // Expected length of slot k of a ramp, clamped and without overshoot.
    function automatic int ramp_len(input int init, input int target, input int step, input int k);
        int cur;
        int t;
        cur = (init < 4) ? 4 : init;
        t   = (target < 4) ? 4 : target;
        for (int i = 0; i < k; i++) begin
            if (cur < t) cur = (cur + step > t) ? t : cur + step;
            else if (cur > t) cur = (cur - step < t) ? t : cur - step;
        end
        return cur;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (vr !== 1'b0)        begin errors++; $display("[TB] FAIL reset_vr: got %0b expected 0", vr); end
        checks++; if (cam !== 1'b0)       begin errors++; $display("[TB] FAIL reset_cam: got %0b expected 0", cam); end
        checks++; if (tooth_idx !== 6'd0) begin errors++; $display("[TB] FAIL reset_tooth: got %0d expected 0", tooth_idx); end
        checks++; if (rev !== 1'b0)       begin errors++; $display("[TB] FAIL reset_rev: got %0b expected 0", rev); end
        checks++; if (sync !== 1'b0)      begin errors++; $display("[TB] FAIL reset_sync: got %0b expected 0", sync); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (busy8 !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy8: got %0b expected 0", busy8); end
        rst = 1'b0;
        tick();
    endtask

    // Two revolutions of a constant 8-cycle wheel, compared cycle by cycle.
    task automatic test_constant_wheel();
        int bad_vr = 0, bad_cam = 0, bad_sync = 0, bad_idx = 0, bad_rev = 0, bad_busy = 0;
        int vr_rises0 = 0, cam_hi0 = 0, cam_hi1 = 0, syncs = 0;
        int slot, ph, r;
        logic exp_vr, exp_cam, exp_sync, prev_vr;
        prev_vr = 1'b0;
        start_run(8, 8, 0);
        for (int c = 0; c < 960; c++) begin
            if (c > 0) tick();
            slot = (c / 8) % 60;
            ph   = c % 8;
            r    = (c / 480) % 2;
            exp_vr   = (slot < 58) && (ph >= 4);
            exp_cam  = (r == 1) && (slot >= 4) && (slot < 54);
            exp_sync = (slot == 0) && (ph == 0);
            if (vr !== exp_vr) bad_vr++;
            if (cam !== exp_cam) bad_cam++;
            if (sync !== exp_sync) bad_sync++;
            if (int'(tooth_idx) != slot) bad_idx++;
            if (int'(rev) != r) bad_rev++;
            if (busy !== 1'b1) bad_busy++;
            if (vr && !prev_vr && r == 0) vr_rises0++;
            prev_vr = vr;
            if (cam && r == 0) cam_hi0++;
            if (cam && r == 1) cam_hi1++;
            if (sync) syncs++;
        end
        checks++; if (bad_vr != 0)    begin errors++; $display("[TB] FAIL const_vr_pattern: got %0d bad cycles expected 0", bad_vr); end
        checks++; if (bad_cam != 0)   begin errors++; $display("[TB] FAIL const_cam_pattern: got %0d bad cycles expected 0", bad_cam); end
        checks++; if (bad_sync != 0)  begin errors++; $display("[TB] FAIL const_sync_pattern: got %0d bad cycles expected 0", bad_sync); end
        checks++; if (bad_idx != 0)   begin errors++; $display("[TB] FAIL const_tooth_idx: got %0d bad cycles expected 0", bad_idx); end
        checks++; if (bad_rev != 0)   begin errors++; $display("[TB] FAIL const_rev: got %0d bad cycles expected 0", bad_rev); end
        checks++; if (bad_busy != 0)  begin errors++; $display("[TB] FAIL const_busy: got %0d bad cycles expected 0", bad_busy); end
        checks++; if (vr_rises0 != 58) begin errors++; $display("[TB] FAIL const_vr_pulses: got %0d expected 58", vr_rises0); end
        checks++; if (cam_hi0 != 0)   begin errors++; $display("[TB] FAIL cam_rev0: got %0d high cycles expected 0", cam_hi0); end
        checks++; if (cam_hi1 != 400) begin errors++; $display("[TB] FAIL cam_rev1: got %0d high cycles expected 400", cam_hi1); end
        checks++; if (syncs != 2)     begin errors++; $display("[TB] FAIL const_sync_count: got %0d expected 2", syncs); end
        do_reset();
    endtask

    task automatic test_ramp(input int init, input int target, input int step, input string tag);
        start_run(init, target, step);
        measure_slots(20);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (slot_len[k] != ramp_len(init, target, step, k)) begin
                errors++;
                $display("[TB] FAIL %s_slot%0d: got %0d expected %0d", tag, k, slot_len[k], ramp_len(init, target, step, k));
            end
        end
        do_reset();
    endtask

    task automatic test_clamp();
        start_run(1, 1, 0);
        measure_slots(3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (slot_len[k] != 4) begin
                errors++;
                $display("[TB] FAIL clamp_slot%0d: got %0d expected 4", k, slot_len[k]);
            end
        end
        do_reset();
    endtask

    // Narrow instance: 250 + 10 would exceed 255, so slot 1 saturates at 255.
    task automatic test_saturation();
        int exp_len [3] = '{250, 255, 255};
        int lens [3];
        int prev_idx, len, k, guard;
        period_init8   = 8'd250;
        period_target8 = 8'd255;
        period_step8   = 8'd10;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        prev_idx = int'(tooth_idx8);
        len = 1; k = 0; guard = 0;
        lens = '{0, 0, 0};
        while (k < 3 && guard < 5000) begin
            tick();
            guard++;
            if (int'(tooth_idx8) != prev_idx) begin
                lens[k] = len; k++; len = 1; prev_idx = int'(tooth_idx8);
            end else begin
                len++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lens[i] != exp_len[i]) begin
                errors++;
                $display("[TB] FAIL sat_slot%0d: got %0d expected %0d", i, lens[i], exp_len[i]);
            end
        end
        do_reset();
    endtask

    // Stop at tooth 10 of rev 0, start attempted during STOPPING.
    task automatic test_stop();
        int syncs = 0, vr_late = 0, rises = 0;
        logic prev_vr;
        prev_vr = 1'b0;
        start_run(8, 8, 0);
        for (int c = 0; c <= 560; c++) begin
            if (c > 0) tick();
            stop  = (c == 80);
            start = (c == 160);
            if (c >= 1 && sync) syncs++;
            if (c >= 480 && vr) vr_late++;
            if (vr && !prev_vr) rises++;
            prev_vr = vr;
            if (c == 479) begin
                checks++; if (busy !== 1'b1)      begin errors++; $display("[TB] FAIL stop_busy_last_slot: got %0b expected 1", busy); end
                checks++; if (tooth_idx !== 6'd59) begin errors++; $display("[TB] FAIL stop_tooth_last_slot: got %0d expected 59", tooth_idx); end
            end
            if (c == 480) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_busy_after: got %0b expected 0", busy); end
            end
        end
        stop = 1'b0;
        start = 1'b0;
        checks++; if (syncs != 0)   begin errors++; $display("[TB] FAIL stop_second_sync: got %0d expected 0", syncs); end
        checks++; if (vr_late != 0) begin errors++; $display("[TB] FAIL stop_vr_after: got %0d high cycles expected 0", vr_late); end
        checks++; if (rises != 58)  begin errors++; $display("[TB] FAIL stop_vr_pulses: got %0d expected 58", rises); end
        do_reset();
    endtask

    // Stop arriving on the final cycle of slot 59 still ends on that edge.
    task automatic test_stop_last_cycle();
        start_run(8, 8, 0);
        repeat (479) tick();
        checks++; if (tooth_idx !== 6'd59) begin errors++; $display("[TB] FAIL stoplast_tooth: got %0d expected 59", tooth_idx); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stoplast_busy: got %0b expected 0", busy); end
        checks++; if (sync !== 1'b0) begin errors++; $display("[TB] FAIL stoplast_sync: got %0b expected 0", sync); end
        do_reset();
    endtask

    // Start and stop together in IDLE: start wins, stop is dropped.
    task automatic test_back_to_back();
        period_init = 16'd8; period_target = 16'd8; period_step = 16'd0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL both_busy_start: got %0b expected 1", busy); end
        repeat (480) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL both_busy_rev1: got %0b expected 1", busy); end
        checks++; if (rev !== 1'b1)  begin errors++; $display("[TB] FAIL both_rev1: got %0b expected 1", rev); end
        checks++; if (sync !== 1'b1) begin errors++; $display("[TB] FAIL both_sync_rev1: got %0b expected 1", sync); end
        do_reset();
    endtask

    task automatic test_reset_mid_run();
        start_run(8, 8, 0);
        repeat (720) tick();
        checks++; if (tooth_idx !== 6'd30) begin errors++; $display("[TB] FAIL mid_pre_tooth: got %0d expected 30", tooth_idx); end
        checks++; if (rev !== 1'b1)        begin errors++; $display("[TB] FAIL mid_pre_rev: got %0b expected 1", rev); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL mid_busy: got %0b expected 0", busy); end
        checks++; if (tooth_idx !== 6'd0)  begin errors++; $display("[TB] FAIL mid_tooth: got %0d expected 0", tooth_idx); end
        checks++; if (rev !== 1'b0)        begin errors++; $display("[TB] FAIL mid_rev: got %0b expected 0", rev); end
        checks++; if (cam !== 1'b0)        begin errors++; $display("[TB] FAIL mid_cam: got %0b expected 0", cam); end
        checks++; if (vr !== 1'b0)         begin errors++; $display("[TB] FAIL mid_vr: got %0b expected 0", vr); end
        checks++; if (sync !== 1'b0)       begin errors++; $display("[TB] FAIL mid_sync: got %0b expected 0", sync); end
        tick();
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL mid_idle_hold: got %0b expected 0", busy); end
        start_run(8, 8, 0);
        checks++; if (sync !== 1'b1)       begin errors++; $display("[TB] FAIL restart_sync: got %0b expected 1", sync); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("[TB] FAIL restart_busy: got %0b expected 1", busy); end
        repeat (240) tick();
        checks++; if (tooth_idx !== 6'd30) begin errors++; $display("[TB] FAIL restart_tooth: got %0d expected 30", tooth_idx); end
        checks++; if (rev !== 1'b0)        begin errors++; $display("[TB] FAIL restart_rev: got %0b expected 0", rev); end
        do_reset();
    endtask

    initial begin
        $display("[TB] trigger_wheel_gen bench starting");
        test_reset();
        test_constant_wheel();
        test_ramp(16, 64, 3, "ramp_up");
        test_ramp(64, 16, 3, "ramp_down");
        test_clamp();
        test_saturation();
        test_stop();
        test_stop_last_cycle();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
